i2s_rx: RTL and testbench

//  I2S slave receiver: deserializes audio from an external ADC/codec (sck, lrck, sdin pins) into

---
 rtl/i2s_rx_pkg.sv | 10 +
 rtl/i2s_pin_sync.sv | 33 +++
 rtl/i2s_rx.sv | 135 +++++++++++++
 tb/tb_i2s_rx.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/i2s_rx_pkg.sv
// Shared I2S receive definitions.
//   CH_LEFT / CH_RIGHT : channel codes carried by word select (lrck)
//   I2S_BIT_DELAY      : data lags word select by this many sck periods
package i2s_rx_pkg;

    localparam logic CH_LEFT       = 1'b0;
    localparam logic CH_RIGHT      = 1'b1;
    localparam int   I2S_BIT_DELAY = 1;

endpackage

// File: rtl/i2s_pin_sync.sv
// Multi-flop synchronizer for one asynchronous pin, with rising-edge detect.
//   clk   in  system clock
//   rst   in  async active-low reset, clears all flops
//   d     in  asynchronous pin
//   q     out synchronized level (STAGES clk cycles behind the pin)
//   rise  out one-cycle pulse when q goes 0->1
module i2s_pin_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic rise
);

    logic [STAGES-1:0] sync_q;
    logic              q_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
            q_d    <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
            q_d    <= sync_q[STAGES-1];
        end
    end

    assign q    = sync_q[STAGES-1];
    assign rise = q & ~q_d;

endmodule

// File: rtl/i2s_rx.sv
// I2S slave receiver: deserializes sdin into left/right sample pairs in the
// clk domain and hands them to a consumer over valid/ready.
//   clk, rst              system clock, async active-low reset
//   sck, lrck, sdin       I2S pins (asynchronous to clk)
//   sample_l, sample_r    completed frame
//   sample_valid          frame pending, held until sample_ready
//   sample_ready          consumer accept
//   overrun               sticky: a pending frame was overwritten
//   overrun_clr           synchronous clear of overrun (a same-cycle set wins)
module i2s_rx
    import i2s_rx_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sck,
    input  logic              lrck,
    input  logic              sdin,
    output logic [DATA_W-1:0] sample_l,
    output logic [DATA_W-1:0] sample_r,
    output logic              sample_valid,
    input  logic              sample_ready,
    output logic              overrun,
    input  logic              overrun_clr
);

    localparam int              CW      = $clog2(DATA_W + 1);
    localparam logic [CW-1:0]   CNT_MAX = CW'(DATA_W);

    logic sck_s, sck_rise, lrck_s, sdin_s;
    logic lrck_rise_unused, sdin_rise_unused, sck_lvl_unused;

    i2s_pin_sync #(.STAGES(SYNC_STAGES)) u_sync_sck (
        .clk(clk), .rst(rst), .d(sck),  .q(sck_s),  .rise(sck_rise));
    i2s_pin_sync #(.STAGES(SYNC_STAGES)) u_sync_lrck (
        .clk(clk), .rst(rst), .d(lrck), .q(lrck_s), .rise(lrck_rise_unused));
    i2s_pin_sync #(.STAGES(SYNC_STAGES)) u_sync_sdin (
        .clk(clk), .rst(rst), .d(sdin), .q(sdin_s), .rise(sdin_rise_unused));

    assign sck_lvl_unused = sck_s;

    // Slot deserializer
    logic [DATA_W-1:0] shreg, word_next;
    logic [CW-1:0]     bitcnt;
    logic              ws_d, slot_started;
    logic              slot_end;

    // Commit stage: one register between slot end and the holding logic;
    // this is the final cycle of the SYNC_STAGES+2 latency.
    logic              commit_vld;
    logic              commit_ch;
    logic [DATA_W-1:0] commit_word;

    // Current bit drops into its MSB-first position; past DATA_W it is ignored.
    always_comb begin
        word_next = shreg;
        for (int i = 0; i < DATA_W; i++) begin
            if (bitcnt < CNT_MAX && i == DATA_W - 1 - int'(bitcnt))
                word_next[i] = sdin_s;
        end
    end

    // lrck changing means this bit is the LSB of the channel still in ws_d.
    assign slot_end = (lrck_s != ws_d);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shreg        <= '0;
            bitcnt       <= '0;
            ws_d         <= 1'b0;
            slot_started <= 1'b0;
            commit_vld   <= 1'b0;
            commit_ch    <= CH_LEFT;
            commit_word  <= '0;
        end else begin
            commit_vld <= 1'b0;
            if (sck_rise) begin
                if (slot_end) begin
                    // The first slot after reset began mid-stream: discard it.
                    commit_vld   <= slot_started;
                    commit_ch    <= ws_d;
                    commit_word  <= word_next;
                    shreg        <= '0;
                    bitcnt       <= '0;
                    slot_started <= 1'b1;
                    ws_d         <= lrck_s;
                end else begin
                    shreg <= word_next;
                    if (bitcnt < CNT_MAX)
                        bitcnt <= bitcnt + 1'b1;
                end
            end
        end
    end

    // Frame assembly and handshake
    logic [DATA_W-1:0] left_hold;
    logic              left_ok;
    logic              accept;

    assign accept = sample_valid & sample_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            left_hold    <= '0;
            left_ok      <= 1'b0;
            sample_l     <= '0;
            sample_r     <= '0;
            sample_valid <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            if (accept)
                sample_valid <= 1'b0;
            if (overrun_clr)
                overrun <= 1'b0;
            if (commit_vld) begin
                if (commit_ch == CH_LEFT) begin
                    left_hold <= commit_word;
                    left_ok   <= 1'b1;
                end else if (left_ok) begin
                    // Right without a preceding left is an orphan and is dropped.
                    sample_l     <= left_hold;
                    sample_r     <= commit_word;
                    sample_valid <= 1'b1;
                    left_ok      <= 1'b0;
                    if (sample_valid && !sample_ready)
                        overrun <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_i2s_rx.sv
// Directed bench for i2s_rx: drives I2S frames pin by pin and checks
// samples, handshake, overrun, latency and reset behaviour.
module tb_i2s_rx;

    localparam int DW   = 16;
    localparam int SS   = 2;
    localparam int HALF = 16;   // sck half period in clk cycles

    logic          clk = 1'b0;
    logic          rst, sck, lrck, sdin, sample_ready, overrun_clr;
    logic [DW-1:0] sample_l, sample_r;
    logic          sample_valid, overrun;

    int total = 0;
    int bad   = 0;
    int n_acc = 0;
    int n0;

    i2s_rx #(.DATA_W(DW), .SYNC_STAGES(SS)) dut (
        .clk(clk), .rst(rst), .sck(sck), .lrck(lrck), .sdin(sdin),
        .sample_l(sample_l), .sample_r(sample_r), .sample_valid(sample_valid),
        .sample_ready(sample_ready), .overrun(overrun), .overrun_clr(overrun_clr));

    always #5 clk = ~clk;

    always @(posedge clk) if (sample_valid && sample_ready) n_acc++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One sck period; pins change 1 time unit after a clk rising edge.
    task automatic send_bit(input logic lr, input logic d);
        sck = 1'b0; lrck = lr; sdin = d;
        repeat (HALF) @(posedge clk);
        #1 sck = 1'b1;
        repeat (HALF - 1) @(posedge clk);
        #1;
    endtask

    // Final rise of a frame (carries right LSB); returns right after sck rises.
    task automatic rise_last(input logic d);
        sck = 1'b0; lrck = 1'b0; sdin = d;
        repeat (HALF) @(posedge clk);
        #1 sck = 1'b1;
    endtask

    // Slot words are left-aligned in 32 bits; nb rises per slot.
    // rel_at >= 0 releases reset before that right-slot bit.
    task automatic frame_body(input logic [31:0] l, input logic [31:0] r,
                              input int nb, input int rel_at);
        for (int j = 0; j < nb - 1; j++) send_bit(1'b0, l[31-j]);
        send_bit(1'b1, l[32-nb]);
        for (int j = 0; j < nb - 1; j++) begin
            if (j == rel_at) rst = 1'b1;
            send_bit(1'b1, r[31-j]);
        end
    endtask

    task automatic send_frame(input logic [31:0] l, input logic [31:0] r, input int nb);
        frame_body(l, r, nb, -1);
        rise_last(r[32-nb]);
        repeat (HALF) @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; sck = 1'b0; lrck = 1'b0; sdin = 1'b0;
        sample_ready = 1'b1; overrun_clr = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("rst_l", sample_l, 0);
        chk("rst_r", sample_r, 0);
        chk("rst_valid", sample_valid, 0);
        chk("rst_overrun", overrun, 0);
        rst = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        // 1: lead-in frame dropped, then one frame with exact latency
        send_frame(32'h7777_0000, 32'h6666_0000, 32);
        chk("t1_leadin_dropped", n_acc, 0);
        chk("t1_leadin_valid", sample_valid, 0);
        frame_body(32'hA5C3_0000, 32'h1234_0000, 32, -1);
        rise_last(1'b0);
        repeat (SS + 1) @(posedge clk);
        #1 chk("t1_valid_early", sample_valid, 0);
        @(posedge clk);
        #1 chk("t1_valid_on_time", sample_valid, 1);
        chk("t1_l", sample_l, 16'hA5C3);
        chk("t1_r", sample_r, 16'h1234);
        @(posedge clk);
        #1 chk("t1_pulse_end", sample_valid, 0);
        chk("t1_acc_count", n_acc, 1);
        repeat (HALF - SS - 3) @(posedge clk);
        #1;

        // 2: reset released mid right slot
        rst = 1'b0;
        frame_body(32'hDEAD_0000, 32'hBEEF_0000, 32, 8);
        rise_last(1'b0);
        repeat (HALF) @(posedge clk);
        #1;
        chk("t2_partial_dropped", sample_valid, 0);
        n0 = n_acc;
        send_frame(32'h0001_0000, 32'h8000_0000, 32);
        chk("t2_l", sample_l, 16'h0001);
        chk("t2_r", sample_r, 16'h8000);
        chk("t2_once", n_acc, n0 + 1);

        // 3: consumer stalled for two frames
        sample_ready = 1'b0;
        send_frame(32'h1111_0000, 32'h2222_0000, 32);
        chk("t3_f1_valid", sample_valid, 1);
        chk("t3_f1_no_overrun", overrun, 0);
        send_frame(32'h3333_0000, 32'h4444_0000, 32);
        chk("t3_l", sample_l, 16'h3333);
        chk("t3_r", sample_r, 16'h4444);
        chk("t3_valid", sample_valid, 1);
        chk("t3_overrun", overrun, 1);
        overrun_clr = 1'b1;
        @(posedge clk);
        #1 overrun_clr = 1'b0;
        chk("t3_overrun_clr", overrun, 0);
        chk("t3_valid_held", sample_valid, 1);
        sample_ready = 1'b1;
        @(posedge clk);
        #1 sample_ready = 1'b0;
        chk("t3_accept", sample_valid, 0);

        // 4: accept coincides with next frame load
        send_frame(32'h5555_0000, 32'h6666_0000, 32);
        chk("t4_f1_valid", sample_valid, 1);
        n0 = n_acc;
        frame_body(32'h7777_0000, 32'h8888_0000, 32, -1);
        rise_last(1'b0);
        repeat (SS + 1) @(posedge clk);
        #1 sample_ready = 1'b1;
        @(posedge clk);
        #1 sample_ready = 1'b0;
        chk("t4_valid", sample_valid, 1);
        chk("t4_l", sample_l, 16'h7777);
        chk("t4_r", sample_r, 16'h8888);
        chk("t4_overrun", overrun, 0);
        chk("t4_acc", n_acc, n0 + 1);
        sample_ready = 1'b1;
        @(posedge clk);
        #1 chk("t4_drain", sample_valid, 0);
        repeat (HALF) @(posedge clk);
        #1;

        // 5: short and long slots
        send_frame(32'hABC0_0000, 32'h1230_0000, 12);
        chk("t5_short_l", sample_l, 16'hABC0);
        chk("t5_short_r", sample_r, 16'h1230);
        send_frame(32'hFEDC_BA00, 32'h0123_4500, 24);
        chk("t5_long_l", sample_l, 16'hFEDC);
        chk("t5_long_r", sample_r, 16'h0123);

        // 6: async reset while a frame is pending
        sample_ready = 1'b0;
        send_frame(32'h9999_0000, 32'hAAAA_0000, 32);
        send_frame(32'hBBBB_0000, 32'hCCCC_0000, 32);
        chk("t6_pre_valid", sample_valid, 1);
        chk("t6_pre_overrun", overrun, 1);
        chk("t6_pre_l", sample_l, 16'hBBBB);
        #2 rst = 1'b0;
        #1;
        chk("t6_valid", sample_valid, 0);
        chk("t6_l", sample_l, 0);
        chk("t6_overrun", overrun, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
